demux1to32_collect: RTL and testbench
=====================================

// Module: demux1to32_collect
// PURPOSE
//  Serial-to-parallel collector: the receive-side counterpart of the 32-to-1 select mux.
//  Takes one data bit per accepted beat and steers it through a 5-to-32 one-hot slot
//  decoder into the next slot of a 32-bit assembly register.
//  Presents the completed word with a valid/ready handshake.
//  Sits between a bit-serial source (the mux output side) and word-wide consumers.
// PARAMETERS
//  N         32  number of slots / output word width (power of 2, 2..32)
//  SW        5   pointer width, log2(N)
//  LSB_FIRST 1   1: beat k fills slot k; 0: beat k fills slot N-1-k
// PORTS
//  CLK  in   1    clock, all state updates on rising edge
//  RST  in   1    synchronous reset, active-high
//  D    in   1    serial data bit
//  V    in   1    D valid this cycle
//  R    out  1    collector ready; a beat is accepted when V & R
//  F    in   1    flush: close the current word early (sampled only when R=1)
//  Y    out  N    assembled word; stable while YV=1
//  YV   out  1    word valid
//  YR   in   1    consumer ready; word consumed when YV & YR
//  CNT  out  SW+1 number of beats in Y, 1..N (0 while filling or empty)
// BEHAVIOUR
//  Reset (RST=1 at a clock edge) forces:
//   - state=FILL, ptr=0, Y=0, YV=0, CNT=0.
//   - R=0 during the RST cycle; R=1 from the first cycle after RST deasserts.
//   - RST mid-word discards all partial data.
//  States: FILL (R=1, YV=0) and HOLD (R=0, YV=1). R and YV are registered/state-decoded.
//  FILL behaviour:
//   - Accepted beat: Y[slot(ptr)] <= D; other bits unchanged; ptr <= ptr+1.
//   - slot() is a one-hot decode of ptr (or ~ptr when LSB_FIRST=0); exactly one bit is written.
//   - When the accepted beat has ptr==N-1: next state HOLD, CNT<=N, ptr wraps to 0.
//   - F=1 with no beat and ptr>0: next state HOLD, CNT<=ptr; unfilled slots stay 0.
//   - F=1 together with an accepted beat: the beat is written first; CNT<=ptr+1, go HOLD.
//   - F=1 with ptr==0 and no beat: ignored (no empty words produced).
//   - V=0 and F=0: hold all state.
//  HOLD behaviour:
//   - D, V and F are ignored (R=0).
//   - On YV & YR: next cycle state=FILL, Y=0, CNT=0, ptr=0, R=1.
//   - No bypass: a beat offered in the same cycle as YR is not accepted.
//   - YV stays high until consumed; Y and CNT do not change in HOLD.
//  Latency: last accepted beat at edge t gives YV=1 after edge t. Minimum full-word period
//   is N+1 cycles (N beats + 1 handshake cycle).
//  Width rules:
//   - ptr is SW bits and wraps modulo N.
//   - CNT is SW+1 bits so the value N is representable.
//   - Upper Y bits beyond N do not exist; N<32 builds use the low SW decoder outputs only.
// TESTING
//  1 Reset: assert RST 2 cycles with V=1, D=1 -> Y=0, YV=0, CNT=0; R=1 one cycle after release.
//  2 Full word, LSB_FIRST=1, YR=1:
//     - stream 32 beats of 0xA5A5_0F0F LSB first -> YV=1 after beat 32, Y=0xA5A5_0F0F, CNT=32.
//     - YV drops and R=1 the next cycle.
//  3 Backpressure: YR=0 for 10 cycles after word with V=1 held
//     -> R=0, Y/CNT unchanged, no beats lost.
//     Then YR=1 -> next word collects from slot 0.
//  4 Flush:
//     - 5 beats 1,0,1,1,0 then F=1 -> Y=0x0000_000D, CNT=5.
//     - F with ptr=0 -> YV stays 0.
//     - F with 6th beat -> CNT=6.
//  5 LSB_FIRST=0: beats 1 then 31 zeros -> Y=0x8000_0000.
//  6 Reset mid-word: after 17 beats pulse RST -> ptr=0, Y=0;
//     next 32 beats of all-ones -> Y=0xFFFF_FFFF, CNT=32.

Source files
------------

// File: rtl/demux1to32_collect.sv
// Serial-to-parallel collector: one bit per accepted beat steered by a one-hot
// slot decoder into an N-bit word, released through a valid/ready handshake.
module demux1to32_collect #(
  parameter int N         = 32,
  parameter int SW        = 5,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          D,
  input  logic          V,
  output logic          R,
  input  logic          F,
  output logic [N-1:0]  Y,
  output logic          YV,
  input  logic          YR,
  output logic [SW:0]   CNT
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [SW-1:0] PTR_MAX = SW'(N - 1);
  localparam logic [N-1:0]  ONE     = N'(1);

  state_e        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  y_q, y_d;
  logic [SW:0]   cnt_q, cnt_d;
  logic          r_q, r_d;
  logic          yv_q, yv_d;

  logic [SW-1:0] idx;
  logic [N-1:0]  dec;
  logic          accept;

  assign idx    = LSB_FIRST ? ptr_q : ~ptr_q;
  assign dec    = ONE << idx;
  assign accept = V & r_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FILL;
      ptr_q   <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      r_q     <= 1'b0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      yv_q    <= yv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          y_d   = (y_q & ~dec) | ({N{D}} & dec);
          ptr_d = ptr_q + SW'(1);
          if ((ptr_q == PTR_MAX) || F) begin
            state_d = HOLD;
            cnt_d   = {1'b0, ptr_q} + (SW+1)'(1);
            ptr_d   = '0;
          end
        end else if (F && r_q && (ptr_q != '0)) begin
          // Early close; unfilled slots are already zero.
          state_d = HOLD;
          cnt_d   = {1'b0, ptr_q};
          ptr_d   = '0;
        end
      end
      HOLD: begin
        if (YR) begin
          state_d = FILL;
          y_d     = '0;
          cnt_d   = '0;
          ptr_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // R and YV come from flops so they stay low through the reset cycle.
  always_comb begin
    r_d  = (state_d == FILL);
    yv_d = (state_d == HOLD);
  end

  assign R   = r_q;
  assign YV  = yv_q;
  assign Y   = y_q;
  assign CNT = cnt_q;

endmodule

// File: tb/tb_demux1to32_collect.sv
// Directed bench for demux1to32_collect: LSB-first and MSB-first instances
// share one stimulus stream.
module tb_demux1to32_collect;

  logic        clk = 1'b0;
  logic        rst, d, v, f, yr;
  logic        r, yv, r2, yv2;
  logic [31:0] y, y2;
  logic [5:0]  cnt, cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  demux1to32_collect #(.N(32), .SW(5), .LSB_FIRST(1'b1)) dut (
    .CLK(clk), .RST(rst), .D(d), .V(v), .R(r), .F(f),
    .Y(y), .YV(yv), .YR(yr), .CNT(cnt)
  );

  demux1to32_collect #(.N(32), .SW(5), .LSB_FIRST(1'b0)) dut_msb (
    .CLK(clk), .RST(rst), .D(d), .V(v), .R(r2), .F(f),
    .Y(y2), .YV(yv2), .YR(yr), .CNT(cnt2)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int w;
    v = 1'b1;
    d = b;
    w = 0;
    while (!r && w < 40) begin
      tick();
      w++;
    end
    if (!r) check("ready_timeout", 64'(r), 64'd1);
    tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int nb);
    for (int i = 0; i < nb; i++) send_bit(w[i]);
    v = 1'b0;
  endtask

  initial begin
    logic bad;
    rst = 1'b1; d = 1'b1; v = 1'b1; f = 1'b0; yr = 1'b1;

    // 1: reset with V/D high
    tick();
    check("rst_r0", 64'(r), 64'd0);
    tick();
    check("rst_y", 64'(y), 64'd0);
    check("rst_yv", 64'(yv), 64'd0);
    check("rst_cnt", 64'(cnt), 64'd0);
    check("rst_r1", 64'(r), 64'd0);
    rst = 1'b0; v = 1'b0;
    tick();
    check("rel_r", 64'(r), 64'd1);
    check("rel_y", 64'(y), 64'd0);

    // 2: full word, consumer ready
    send_word(32'hA5A5_0F0F, 32);
    check("full_yv", 64'(yv), 64'd1);
    check("full_y", 64'(y), 64'hA5A5_0F0F);
    check("full_cnt", 64'(cnt), 64'd32);
    check("full_r", 64'(r), 64'd0);
    check("msb_full_y", 64'(y2), 64'hF0F0_A5A5);
    tick();
    check("cons_yv", 64'(yv), 64'd0);
    check("cons_r", 64'(r), 64'd1);
    check("cons_y", 64'(y), 64'd0);
    check("cons_cnt", 64'(cnt), 64'd0);

    // 3: backpressure with beats offered during hold
    yr = 1'b0;
    send_word(32'h1234_5678, 32);
    v = 1'b1; d = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (r !== 1'b0 || yv !== 1'b1 || y !== 32'h1234_5678 || cnt !== 6'd32)
        bad = 1'b1;
    end
    check("bp_stable", 64'(bad), 64'd0);
    check("bp_y", 64'(y), 64'h1234_5678);
    v = 1'b0; yr = 1'b1;
    tick();
    check("bp_rel_yv", 64'(yv), 64'd0);
    check("bp_rel_r", 64'(r), 64'd1);
    send_word(32'h3, 2);
    f = 1'b1;
    tick();
    f = 1'b0;
    check("bp_next_y", 64'(y), 64'h3);
    check("bp_next_cnt", 64'(cnt), 64'd2);
    tick();

    // 4: flush variants
    send_word(32'b01101, 5);
    f = 1'b1;
    tick();
    f = 1'b0;
    check("fl5_yv", 64'(yv), 64'd1);
    check("fl5_y", 64'(y), 64'hD);
    check("fl5_cnt", 64'(cnt), 64'd5);
    tick();
    f = 1'b1;
    tick();
    f = 1'b0;
    check("fl0_yv", 64'(yv), 64'd0);
    check("fl0_r", 64'(r), 64'd1);
    send_word(32'h1F, 5);
    f = 1'b1;
    send_bit(1'b1);
    v = 1'b0; f = 1'b0;
    check("fl6_yv", 64'(yv), 64'd1);
    check("fl6_cnt", 64'(cnt), 64'd6);
    check("fl6_y", 64'(y), 64'h3F);
    tick();

    // 5: MSB-first slot order
    send_word(32'h1, 32);
    check("msb_y", 64'(y2), 64'h8000_0000);
    check("msb_cnt", 64'(cnt2), 64'd32);
    check("lsb_y", 64'(y), 64'h1);
    tick();

    // 6: reset mid-word
    send_word(32'hFFFF_FFFF, 17);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_y", 64'(y), 64'd0);
    check("mid_r", 64'(r), 64'd0);
    check("mid_yv", 64'(yv), 64'd0);
    tick();
    check("mid_rel_r", 64'(r), 64'd1);
    send_word(32'hFFFF_FFFF, 32);
    check("ones_y", 64'(y), 64'hFFFF_FFFF);
    check("ones_cnt", 64'(cnt), 64'd32);
    check("ones_yv", 64'(yv), 64'd1);
    tick();
    check("ones_cons", 64'(yv), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
